// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - guarded three-step operand/opcode loader for the 4-bit ALU
//
// Purpose: debounces one load pushbutton and uses each press to capture
// operand a, operand b and then the opcode from the switches, holding them
// stable for the downstream ALU and flagging a complete, legal operation.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   btn_n  in   raw asynchronous load pushbutton, low = pressed
//   clr    in   synchronous clear, active high
//   sw     in   operand switches [N-1:0]
//   op_sw  in   opcode switches [2:0]
//   a      out  registered operand a
//   b      out  registered operand b
//   op     out  registered opcode
//   valid  out  a/b/op form a complete, legal operation
//   step   out  current entry step (S_A=0, S_B=1, S_OP=2, S_DONE=3)
//   err    out  one-cycle pulse on a rejected opcode
module alu_operand_loader #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int OP_MAX          = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         btn_n,
  input  logic         clr,
  input  logic [N-1:0] sw,
  input  logic [2:0]   op_sw,
  output logic [N-1:0] a,
  output logic [N-1:0] b,
  output logic [2:0]   op,
  output logic         valid,
  output logic [1:0]   step,
  output logic         err
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]    OP_LIM  = 3'(OP_MAX);

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_OP   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  logic          sync1, sync2;
  logic          deb, deb_d;
  logic [CW-1:0] cnt;
  logic          press;

  state_t        state, state_nx;
  logic [N-1:0]  a_nx, b_nx;
  logic [2:0]    op_nx;
  logic          valid_nx, err_nx;

  // Two-flop synchronizer; idle (released) level is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // Debounce: the new level must persist DEBOUNCE_CYCLES consecutive cycles;
  // any return to the accepted level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb <= 1'b1;
      cnt <= '0;
    end else if (sync2 == deb) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      deb <= sync2;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Press pulse lands in the cycle after deb falls; release makes no event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_d <= 1'b1;
      press <= 1'b0;
    end else begin
      deb_d <= deb;
      press <= deb_d & ~deb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_A;
      a     <= '0;
      b     <= '0;
      op    <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      a     <= a_nx;
      b     <= b_nx;
      op    <= op_nx;
      valid <= valid_nx;
      err   <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    a_nx     = a;
    b_nx     = b;
    op_nx    = op;
    valid_nx = valid;
    err_nx   = 1'b0;
    // clr takes priority and swallows any press arriving on the same edge.
    if (clr) begin
      state_nx = S_A;
      a_nx     = '0;
      b_nx     = '0;
      op_nx    = '0;
      valid_nx = 1'b0;
    end else if (press) begin
      case (state)
        S_A: begin
          a_nx     = sw;
          state_nx = S_B;
        end
        S_B: begin
          b_nx     = sw;
          state_nx = S_OP;
        end
        S_OP: begin
          if (op_sw <= OP_LIM) begin
            op_nx    = op_sw;
            valid_nx = 1'b1;
            state_nx = S_DONE;
          end else begin
            err_nx = 1'b1;
          end
        end
        S_DONE: begin
          valid_nx = 1'b0;
          state_nx = S_A;
        end
        default: state_nx = S_A;
      endcase
    end
  end

  assign step = state;

endmodule
